// File: rtl/smc_rdata_lite16_if.sv
// Bus-side signal bundle for the lite SMC read-data assembler.
// The master drives the transfer, access and data inputs. The slave (the
// assembler) returns the assembled word and its status pulses.
interface smc_rdata_lite16_if;
    logic        valid_access16;
    logic        v_write16;
    logic [1:0]  v_xfer_size16;
    logic [1:0]  v_bus_size16;
    logic [1:0]  smc_addr_lsb16;
    logic        smc_rd_strobe16;
    logic [31:0] data_smc16;
    logic [31:0] smc_rdata16;
    logic        smc_rvalid16;
    logic        smc_rbusy16;
    logic        smc_rerr16;

    modport master (
        output valid_access16, v_write16, v_xfer_size16, v_bus_size16,
               smc_addr_lsb16, smc_rd_strobe16, data_smc16,
        input  smc_rdata16, smc_rvalid16, smc_rbusy16, smc_rerr16
    );

    modport slave (
        input  valid_access16, v_write16, v_xfer_size16, v_bus_size16,
               smc_addr_lsb16, smc_rd_strobe16, data_smc16,
        output smc_rdata16, smc_rvalid16, smc_rbusy16, smc_rerr16
    );
endinterface

// File: rtl/smc_rdata_lite16.sv
// Read-data assembler: packs 1, 2 or 4 narrow external reads into one
// 32-bit AHB word. Byte lanes are chosen by the access LSB address, so any
// access order assembles correctly. All outputs are registered.
module smc_rdata_lite16 (
    input  logic                 sys_clk16,
    input  logic                 n_sys_reset16,
    smc_rdata_lite16_if.slave    bus
);

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    // Number of external accesses that make up one transfer.
    function automatic logic [2:0] access_count(input logic [1:0] xfer_sz,
                                                input logic [1:0] bus_sz);
        logic [2:0] n;
        case ({xfer_sz, bus_sz})
            4'b10_00:          n = 3'd4;
            4'b10_01, 4'b01_00: n = 3'd2;
            default:           n = 3'd1;
        endcase
        return n;
    endfunction

    // Drop one external chunk into its byte lanes; other bytes keep their value.
    function automatic logic [31:0] merge_chunk(input logic [31:0] acc,
                                                input logic [31:0] data,
                                                input logic [1:0]  bus_sz,
                                                input logic [1:0]  lsb);
        logic [31:0] r;
        r = acc;
        case (bus_sz)
            2'b10: r = data;
            2'b01: begin
                if (lsb[1]) begin
                    r[31:16] = data[15:0];
                end else begin
                    r[15:0] = data[15:0];
                end
            end
            2'b00: begin
                case (lsb)
                    2'b00:   r[7:0]   = data[7:0];
                    2'b01:   r[15:8]  = data[7:0];
                    2'b10:   r[23:16] = data[7:0];
                    2'b11:   r[31:24] = data[7:0];
                    default: r = acc;
                endcase
            end
            default: r = acc;
        endcase
        return r;
    endfunction

    state_t      state_r;
    state_t      next_state_s;
    logic [1:0]  bus_sz_r;
    logic [2:0]  count_r;
    logic [31:0] acc_r;
    logic [31:0] rdata_r;
    logic        rvalid_r;
    logic        rbusy_r;
    logic        rerr_r;

    logic        sizes_ok_s;
    logic        start_s;
    logic        accept_s;
    logic        done_s;
    logic        err_s;
    logic [31:0] merged_s;

    assign sizes_ok_s = (bus.v_xfer_size16 != 2'b11) && (bus.v_bus_size16 != 2'b11);
    assign merged_s   = merge_chunk(acc_r, bus.data_smc16, bus_sz_r, bus.smc_addr_lsb16);

    // State register.
    always_ff @(posedge sys_clk16 or negedge n_sys_reset16) begin
        if (!n_sys_reset16) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next state, transfer start/accept/complete and protocol-error decode.
    always_comb begin
        next_state_s = state_r;
        start_s      = 1'b0;
        accept_s     = 1'b0;
        done_s       = 1'b0;
        err_s        = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.valid_access16 && !bus.v_write16) begin
                    if (sizes_ok_s) begin
                        start_s      = 1'b1;
                        next_state_s = COLLECT;
                    end else begin
                        err_s = 1'b1;
                    end
                end else begin
                    next_state_s = IDLE;
                end
                // Stray strobe, or strobe colliding with a new transfer.
                if (bus.smc_rd_strobe16) begin
                    err_s = 1'b1;
                end else begin
                    accept_s = 1'b0;
                end
            end
            COLLECT: begin
                if (bus.valid_access16) begin
                    // Abort; any strobe this cycle is discarded with it.
                    err_s = 1'b1;
                    if (!bus.v_write16 && sizes_ok_s) begin
                        start_s      = 1'b1;
                        next_state_s = COLLECT;
                    end else begin
                        next_state_s = IDLE;
                    end
                end else if (bus.smc_rd_strobe16) begin
                    accept_s = 1'b1;
                    if (count_r == 3'd1) begin
                        done_s       = 1'b1;
                        next_state_s = IDLE;
                    end else begin
                        next_state_s = COLLECT;
                    end
                end else begin
                    next_state_s = COLLECT;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // Accumulator, access counter and registered outputs.
    always_ff @(posedge sys_clk16 or negedge n_sys_reset16) begin
        if (!n_sys_reset16) begin
            bus_sz_r <= 2'b00;
            count_r  <= 3'd0;
            acc_r    <= 32'd0;
            rdata_r  <= 32'd0;
            rvalid_r <= 1'b0;
            rbusy_r  <= 1'b0;
            rerr_r   <= 1'b0;
        end else begin
            if (start_s) begin
                bus_sz_r <= bus.v_bus_size16;
                count_r  <= access_count(bus.v_xfer_size16, bus.v_bus_size16);
                acc_r    <= 32'd0;
            end else if (accept_s) begin
                count_r <= count_r - 3'd1;
                acc_r   <= merged_s;
            end
            if (done_s) begin
                rdata_r <= merged_s;
            end
            rvalid_r <= done_s;
            rerr_r   <= err_s;
            rbusy_r  <= (next_state_s == COLLECT);
        end
    end

    assign bus.smc_rdata16  = rdata_r;
    assign bus.smc_rvalid16 = rvalid_r;
    assign bus.smc_rbusy16  = rbusy_r;
    assign bus.smc_rerr16   = rerr_r;

endmodule
